// File: rtl/ifetch_unit.sv
// rtl/ifetch_unit.sv - instruction fetch stage: PC accept, held imem read, decode handshake
// Optional feature: define IFETCH_ALIGN_CHECK_EN to fault on misaligned PCs.
module ifetch_unit #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] pc,
    input  logic              pc_valid,
    output logic              pc_take,
    input  logic              flush,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid,
    input  logic              decode_ready,
    output logic              fetch_fault
);

    typedef enum logic [1:0] {IDLE, REQ, VALID} state_t;

    state_t            state;
    state_t            state_next;
    logic              flush_pending;
    logic [ADDR_W-1:0] req_pc;
    logic              accept_slot;
    logic              accept_ok;
    logic              misaligned;
    logic              issue;
    logic              capture;
    logic              fault_q;

    // A new PC may be taken from IDLE, or from VALID on the very edge decode consumes the word.
    assign accept_slot = (state == IDLE) || (state == VALID && decode_ready && !flush);
    assign accept_ok   = accept_slot && pc_valid && !flush && !fault_q;
    assign issue       = accept_ok && !misaligned;

`ifdef IFETCH_ALIGN_CHECK_EN
    logic fault_set;

    assign misaligned = (pc[1:0] != 2'b00);
    assign fault_set  = accept_ok && misaligned;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fault_q <= 1'b0;
        end else if (flush) begin
            fault_q <= 1'b0;
        end else if (fault_set) begin
            fault_q <= 1'b1;
        end
    end
`else
    assign misaligned = 1'b0;
    assign fault_q    = 1'b0;
`endif

    assign fetch_fault = fault_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        capture    = 1'b0;
        case (state)
            IDLE:  state_next = IDLE;
            REQ: begin
                if (imem_ack) begin
                    capture    = !(flush || flush_pending);
                    state_next = capture ? VALID : IDLE;
                end
            end
            VALID: begin
                if (flush || decode_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        if (issue) begin
            state_next = REQ;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc_take       <= 1'b0;
            imem_req      <= 1'b0;
            imem_addr     <= '0;
            req_pc        <= '0;
            flush_pending <= 1'b0;
            instr         <= '0;
            instr_pc      <= '0;
            instr_valid   <= 1'b0;
        end else begin
            pc_take <= issue;

            if (issue) begin
                imem_req  <= 1'b1;
                imem_addr <= pc;
                req_pc    <= pc;
            end else if (state == REQ && imem_ack) begin
                imem_req <= 1'b0;
            end

            // The request cannot be retracted, so a flush while waiting only marks the reply stale.
            if (state == REQ) begin
                if (imem_ack) begin
                    flush_pending <= 1'b0;
                end else if (flush) begin
                    flush_pending <= 1'b1;
                end
            end

            if (capture) begin
                instr       <= imem_rdata;
                instr_pc    <= req_pc;
                instr_valid <= 1'b1;
            end else if (state == VALID && (flush || decode_ready)) begin
                instr_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ifetch_unit.sv
// tb/tb_ifetch_unit.sv - randomized bench for ifetch_unit against a transaction-level reference model
module tb_ifetch_unit;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int NCYC   = 3000;

`ifdef IFETCH_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    logic              clock;
    logic              reset;
    logic [ADDR_W-1:0] pc;
    logic              pc_valid;
    logic              pc_take;
    logic              flush;
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack;
    logic [DATA_W-1:0] imem_rdata;
    logic [DATA_W-1:0] instr;
    logic [ADDR_W-1:0] instr_pc;
    logic              instr_valid;
    logic              decode_ready;
    logic              fetch_fault;

    int errors = 0;
    int checks = 0;

    ifetch_unit #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clock       (clock),
        .reset       (reset),
        .pc          (pc),
        .pc_valid    (pc_valid),
        .pc_take     (pc_take),
        .flush       (flush),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .decode_ready(decode_ready),
        .fetch_fault (fetch_fault)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference: one outstanding read (addr), one held word for decode, a stale-reply flag, sticky fault.
    bit              m_outstanding;
    bit [ADDR_W-1:0] m_addr;
    bit              m_took;
    bit              m_held;
    bit [DATA_W-1:0] m_word;
    bit [ADDR_W-1:0] m_word_pc;
    bit              m_stale;
    bit              m_fault;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_outstanding = 0;
        m_addr        = '0;
        m_took        = 0;
        m_held        = 0;
        m_word        = '0;
        m_word_pc     = '0;
        m_stale       = 0;
        m_fault       = 0;
    endtask

    task automatic model_step();
        bit can_take;
        m_took = 0;
        if (m_outstanding) begin
            if (imem_ack) begin
                m_outstanding = 0;
                if (flush || m_stale) begin
                    m_stale = 0;
                end else begin
                    m_held    = 1;
                    m_word    = imem_rdata;
                    m_word_pc = m_addr;
                end
            end else if (flush) begin
                m_stale = 1;
            end
        end else begin
            can_take = !m_held || (decode_ready && !flush);
            if (m_held && (flush || decode_ready)) m_held = 0;
            if (flush) begin
                m_fault = 0;
            end else if (can_take && pc_valid && !m_fault) begin
                if (ALIGN && pc[1:0] != 2'b00) begin
                    m_fault = 1;
                end else begin
                    m_outstanding = 1;
                    m_addr        = pc;
                    m_took        = 1;
                end
            end
        end
    endtask

    task automatic compare_all();
        check_eq("imem_req",    imem_req,    m_outstanding);
        check_eq("imem_addr",   imem_addr,   m_addr);
        check_eq("pc_take",     pc_take,     m_took);
        check_eq("instr_valid", instr_valid, m_held);
        check_eq("instr",       instr,       m_word);
        check_eq("instr_pc",    instr_pc,    m_word_pc);
        check_eq("fetch_fault", fetch_fault, m_fault);
    endtask

    task automatic drive(input int cyc);
        case (cyc)
            0: begin pc = 32'h0040_0000; pc_valid = 1; flush = 0; imem_ack = 0; decode_ready = 1; end
            1: begin pc_valid = 0; imem_ack = 1; imem_rdata = 32'h2008_000A; end
            2: begin imem_ack = 0; decode_ready = 0; end
            3: begin pc = 32'h0040_0002; pc_valid = 1; decode_ready = 1; end
            4: begin pc = 32'h0040_0100; end
            5: begin flush = 1; pc_valid = 0; end
            6: begin flush = 0; pc_valid = 1; end
            default: begin
                pc_valid     = ($urandom_range(0, 9) < 7);
                pc           = {$urandom_range(0, 15), 4'h0, 14'h0, $urandom_range(0, 1023) & 10'h3FC,
                                (($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'b00)};
                flush        = ($urandom_range(0, 9) == 0);
                imem_ack     = ($urandom_range(0, 9) < 4);
                imem_rdata   = $urandom;
                decode_ready = ($urandom_range(0, 9) < 6);
            end
        endcase
    endtask

    initial begin
        reset        = 1'b0;
        pc           = '0;
        pc_valid     = 1'b0;
        flush        = 1'b0;
        imem_ack     = 1'b0;
        imem_rdata   = '0;
        decode_ready = 1'b0;
        model_reset();
        repeat (2) @(negedge clock);
        compare_all();
        reset = 1'b1;

        for (int cyc = 0; cyc < NCYC; cyc++) begin
            if (cyc == NCYC / 2) begin
                reset = 1'b0;
                #1;
                model_reset();
                compare_all();
                #1 reset = 1'b1;
            end
            drive(cyc);
            model_step();
            @(negedge clock);
            compare_all();
            if (cyc == 1) begin
                check_eq("first_instr", instr, 32'h2008_000A);
                check_eq("first_pc",    instr_pc, 32'h0040_0000);
            end
            if (cyc == 3) check_eq("misaligned_fault", fetch_fault, ALIGN);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
